// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches from a combinational word-indexed
// memory into a prefetch queue for decode. Optional perf counters under FETCH_PERF_EN.
module fetch_sequencer #(
    parameter int                 ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter int                 MEM_WORDS = 128,
    parameter int                 Q_DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rd,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fault,
    output logic [1:0]        state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
`endif
);

    localparam int PW = $clog2(Q_DEPTH);
    localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [PW:0]     Q_FULL  = (PW+1)'(Q_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_HALTED = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [PW:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] qpc_q  [Q_DEPTH];
    logic [31:0]       qins_q [Q_DEPTH];

    logic in_range, full, pop, do_pop, push, flush;

    assign in_range    = {1'b0, pc_q} < MEM_LIM;
    assign full        = (cnt_q == Q_FULL);
    assign instr_valid = (cnt_q != '0);
    assign pop         = instr_valid && instr_ready;
    assign imem_addr   = pc_q;
    assign instr       = instr_valid ? qins_q[rptr_q] : '0;
    assign instr_pc    = instr_valid ? qpc_q[rptr_q]  : '0;
    assign fault       = (state_q == S_FAULT);
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            default: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (state_q == S_FETCH) begin
                    // Out-of-range outranks halt so a halted PC is never beyond memory.
                    if (!in_range) begin
                        state_d = S_FAULT;
                    end else if (halt) begin
                        state_d = S_HALTED;
                    end else if (!full || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign do_pop = pop && !flush;

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (push)   wptr_d = wptr_q + 1'b1;
            if (do_pop) rptr_d = rptr_q + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            rptr_q  <= '0;
            wptr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Queue payload carries no reset; validity comes from cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            qpc_q[wptr_q]  <= pc_q;
            qins_q[wptr_q] <= imem_rd;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [31:0] perf_fetched_q, perf_stalls_q;
    logic        stall;

    assign stall = (state_q == S_FETCH) && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            if (push)  perf_fetched_q <= sat_inc(perf_fetched_q);
            if (stall) perf_stalls_q  <= sat_inc(perf_stalls_q);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: scoreboard of expected PCs, checked on each handshake.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        fault;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    assign imem_rd = 32'h1000_0000 + imem_addr;

    fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'd0), .MEM_WORDS(128), .Q_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_addr   (imem_addr),
        .imem_rd     (imem_rd),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fault       (fault),
        .state       (state)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stalls (perf_stalls)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Score any handshake in the current cycle, then advance to just after the next edge.
    task automatic tick();
        logic [31:0] e;
        if (instr_valid && instr_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
            chk("pop_pc", instr_pc, e);
            chk("pop_instr", instr, 32'h1000_0000 + e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
        for (logic [31:0] p = lo; p <= hi; p++) exp_q.push_back(p);
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while (exp_q.size() > 0 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        instr_ready = 1'b0;
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and unobstructed stream
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        push_range(0, 19);
        tick();
        tick();
        chk("s1_first_valid", 32'(instr_valid), 32'd1);
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        chk("s1_no_bubbles", 32'(n), 32'd20);

        // Fill queue, then reset mid-operation
        instr_ready = 1'b0;
        repeat (3) tick();
        chk("s6_full_pc", instr_pc, 32'd20);
        chk("s6_full_addr", imem_addr, 32'd22);
        rst_n = 1'b0;
        tick();
        chk("s6_valid", 32'(instr_valid), 32'd0);
        chk("s6_addr", imem_addr, 32'd0);
        chk("s6_state", 32'(state), 32'd0);
        rst_n = 1'b1;

        // Backpressure from the start
        repeat (5) tick();
        chk("s2_valid", 32'(instr_valid), 32'd1);
        chk("s2_head_pc", instr_pc, 32'd0);
        chk("s2_addr_hold", imem_addr, 32'd2);
        chk("s2_state", 32'(state), 32'd1);
`ifdef FETCH_PERF_EN
        chk("s2_perf_stalls", perf_stalls, 32'd2);
        chk("s2_perf_fetched", perf_fetched, 32'd2);
`endif
        push_range(0, 4);
        instr_ready = 1'b1;
        drain("s2_drain", 20);
        instr_ready = 1'b0;
        chk("s3_pre_head", instr_pc, 32'd5);
        chk("s3_pre_addr", imem_addr, 32'd7);

        // Redirect flushes queued PCs 5,6
        do_redirect(32'h40);
        chk("s3_flush_valid", 32'(instr_valid), 32'd0);
        chk("s3_addr", imem_addr, 32'h40);
        tick();
        chk("s3_first_valid", 32'(instr_valid), 32'd1);
        chk("s3_first_pc", instr_pc, 32'h40);
        push_range(32'h40, 32'h44);
        instr_ready = 1'b1;
        drain("s3_drain", 20);

        // Halt at PC 10
        do_redirect(32'd0);
        push_range(0, 9);
        instr_ready = 1'b1;
        n = 0;
        while (imem_addr != 32'd10 && n < 40) begin
            tick();
            n++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("s4_drained", 32'(exp_q.size()), 32'd0);
        chk("s4_state", 32'(state), 32'd2);
        repeat (3) tick();
        chk("s4_addr_hold", imem_addr, 32'd10);
        chk("s4_state_hold", 32'(state), 32'd2);
        chk("s4_valid", 32'(instr_valid), 32'd0);
        do_redirect(32'd3);
        chk("s4_resume_state", 32'(state), 32'd1);
        push_range(3, 6);
        instr_ready = 1'b1;
        drain("s4_drain", 20);

        // Run off the end of memory, with halt colliding with the fault
        do_redirect(32'd120);
        push_range(120, 127);
        instr_ready = 1'b1;
        n = 0;
        while (imem_addr != 32'd128 && n < 40) begin
            tick();
            n++;
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("s5_state", 32'(state), 32'd3);
        chk("s5_fault", 32'(fault), 32'd1);
        chk("s5_addr", imem_addr, 32'd128);
        chk("s5_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        chk("s5_state_hold", 32'(state), 32'd3);
        chk("s5_valid", 32'(instr_valid), 32'd0);
        do_redirect(32'd0);
        chk("s5_fault_clr", 32'(fault), 32'd0);
        chk("s5_resume_state", 32'(state), 32'd1);
        chk("s5_resume_addr", imem_addr, 32'd0);
        push_range(0, 2);
        instr_ready = 1'b1;
        drain("s5_drain", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
